// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared VGA timing constants, types, FSM states and colour-bar lookup.
package vga_timing_pkg;
  typedef struct packed {
    int unsigned h_active;
    int unsigned h_fp;
    int unsigned h_sync;
    int unsigned h_bp;
    int unsigned v_active;
    int unsigned v_fp;
    int unsigned v_sync;
    int unsigned v_bp;
  } vga_timing_t;
  typedef logic [11:0] rgb12_t;
  typedef enum logic {HOLD, RUN} vga_state_t;
  localparam vga_timing_t VGA_640X480 = '{640, 16, 96, 48, 480, 10, 2, 33};
  localparam int DEF_CLK_DIV = 4;
  // bar 0 (white) in the low bits through bar 7 (black) in the high bits
  localparam logic [95:0] BARS = {12'h000, 12'h00F, 12'hF00, 12'hF0F,
                                  12'h0F0, 12'h0FF, 12'hFF0, 12'hFFF};
  function automatic rgb12_t color_bar(input logic [2:0] idx);
    return BARS[32'(idx) * 12 +: 12];
  endfunction
endpackage

// File: rtl/clk_en_div.sv
// clk_en_div: one-clk enable pulse every CLK_DIV system clocks, async active-low reset.
module clk_en_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic pix_ce
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);
  logic [DW-1:0] div_cnt, div_nxt;
  assign div_nxt = div_cnt == LAST ? '0 : div_cnt + 1'b1;
  // registered so pix_ce is high exactly while div_cnt == CLK_DIV-1, and 0 in reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      div_cnt <= '0;
      pix_ce <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      pix_ce <= div_nxt == LAST;
    end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator with RUN/HOLD frame gating.
// Optional colour-bar output on rgb when VGA_TEST_PATTERN_EN is defined.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int H_ACTIVE = VGA_640X480.h_active,
  parameter int H_FP     = VGA_640X480.h_fp,
  parameter int H_SYNC   = VGA_640X480.h_sync,
  parameter int H_BP     = VGA_640X480.h_bp,
  parameter int V_ACTIVE = VGA_640X480.v_active,
  parameter int V_FP     = VGA_640X480.v_fp,
  parameter int V_SYNC   = VGA_640X480.v_sync,
  parameter int V_BP     = VGA_640X480.v_bp,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int FRAME_W  = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  output logic                        pix_ce,
  output logic                        hSync,
  output logic                        vSync,
  output logic                        bright,
  output logic [$clog2(H_ACTIVE)-1:0] x,
  output logic [$clog2(V_ACTIVE)-1:0] y,
  output logic                        line_start,
  output logic                        frame_start,
  output logic [FRAME_W-1:0]          frame_cnt
`ifdef VGA_TEST_PATTERN_EN
  ,
  output rgb12_t                      rgb
`endif
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int XW = $clog2(H_ACTIVE);
  localparam int YW = $clog2(V_ACTIVE);
  vga_state_t state, state_nxt;
  logic [HW-1:0] h_cnt, h_nxt;
  logic [VW-1:0] v_cnt, v_nxt;
  logic run, h_last, v_last, frame_end, h_act, v_act, h_syn, v_syn, vis;
  clk_en_div #(.CLK_DIV(CLK_DIV)) u_div (.clk(clk), .rst_n(rst_n), .pix_ce(pix_ce));
  assign run = state == RUN;
  assign h_last = int'(h_cnt) == H_TOTAL - 1;
  assign v_last = int'(v_cnt) == V_TOTAL - 1;
  assign frame_end = h_last && v_last;
  assign h_act = int'(h_cnt) < H_ACTIVE;
  assign v_act = int'(v_cnt) < V_ACTIVE;
  assign h_syn = int'(h_cnt) >= H_ACTIVE + H_FP && int'(h_cnt) < H_ACTIVE + H_FP + H_SYNC;
  assign v_syn = int'(v_cnt) >= V_ACTIVE + V_FP && int'(v_cnt) < V_ACTIVE + V_FP + V_SYNC;
  assign vis = run && h_act && v_act;
  always_comb begin
    state_nxt = state;
    h_nxt = h_cnt;
    v_nxt = v_cnt;
    if (run) begin
      state_nxt = frame_end && !en ? HOLD : RUN;
      h_nxt = h_last ? '0 : h_cnt + 1'b1;
      v_nxt = h_last ? (v_last ? '0 : v_cnt + 1'b1) : v_cnt;
    end else begin
      state_nxt = en ? RUN : HOLD;
    end
  end
  // outputs decode the counters present at the pix_ce edge, so they lag them by one pixel
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= HOLD;
      h_cnt <= '0;
      v_cnt <= '0;
      hSync <= ~H_POL;
      vSync <= ~V_POL;
      bright <= 1'b0;
      x <= '0;
      y <= '0;
      line_start <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt <= '0;
    end else if (pix_ce) begin
      state <= state_nxt;
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
      hSync <= run && h_syn ? H_POL : ~H_POL;
      vSync <= run && v_syn ? V_POL : ~V_POL;
      bright <= vis;
      x <= vis ? XW'(h_cnt) : '0;
      y <= vis ? YW'(v_cnt) : '0;
      line_start <= run && h_cnt == '0 && v_act;
      frame_start <= run && h_cnt == '0 && v_cnt == '0;
      frame_cnt <= frame_cnt + FRAME_W'(run && frame_end);
    end
`ifdef VGA_TEST_PATTERN_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rgb <= '0;
    else if (pix_ce) rgb <= vis ? color_bar(3'(int'(h_cnt) * 8 / H_ACTIVE)) : '0;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed self-checking bench on a 14x8 raster with CLK_DIV=2.
module tb_vga_timing_gen;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0;
  logic pix_ce, hSync, vSync, bright, line_start, frame_start;
  logic [2:0] x;
  logic [1:0] y;
  logic [15:0] frame_cnt;
  int tests = 0, fails = 0;
`ifdef VGA_TEST_PATTERN_EN
  logic [11:0] rgb;
  logic [11:0] bars [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
`endif
  always #5 clk = ~clk;
  vga_timing_gen #(
    .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .pix_ce(pix_ce), .hSync(hSync), .vSync(vSync),
    .bright(bright), .x(x), .y(y), .line_start(line_start), .frame_start(frame_start),
    .frame_cnt(frame_cnt)
`ifdef VGA_TEST_PATTERN_EN
    , .rgb(rgb)
`endif
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  task automatic next_pix();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!pix_ce && n < 8);
    if (n >= 8) check("pix_ce_timeout", 32'(pix_ce), 1);
    @(posedge clk);
    #1;
  endtask
  task automatic check_idle(input string tag, input int fc);
    check({tag, "_bright"}, 32'(bright), 0);
    check({tag, "_hsync"}, 32'(hSync), 1);
    check({tag, "_vsync"}, 32'(vSync), 1);
    check({tag, "_fstart"}, 32'(frame_start), 0);
    check({tag, "_fcnt"}, 32'(frame_cnt), 32'(fc));
  endtask
  task automatic check_pix(input int k);
    int f, p, h, v;
    logic vis;
    f = k / 112;
    p = k % 112;
    h = p % 14;
    v = p / 14;
    vis = h < 8 && v < 4;
    check($sformatf("bright@%0d", k), 32'(bright), 32'(vis));
    check($sformatf("x@%0d", k), 32'(x), vis ? h : 0);
    check($sformatf("y@%0d", k), 32'(y), vis ? v : 0);
    check($sformatf("hsync@%0d", k), 32'(hSync), 32'(!(h >= 10 && h < 13)));
    check($sformatf("vsync@%0d", k), 32'(vSync), 32'(!(v >= 5 && v < 7)));
    check($sformatf("lstart@%0d", k), 32'(line_start), 32'(h == 0 && v < 4));
    check($sformatf("fstart@%0d", k), 32'(frame_start), 32'(p == 0));
    check($sformatf("fcnt@%0d", k), 32'(frame_cnt), 32'(f + (p == 111 ? 1 : 0)));
`ifdef VGA_TEST_PATTERN_EN
    check($sformatf("rgb@%0d", k), 32'(rgb), vis ? 32'(bars[h]) : 0);
`endif
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("rst_pix_ce", 32'(pix_ce), 0);
    check("rst_x", 32'(x), 0);
    check("rst_y", 32'(y), 0);
    check("rst_lstart", 32'(line_start), 0);
    check_idle("rst", 0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("pce_toggle%0d", i), 32'(pix_ce), 32'(i % 2 == 0));
      check_idle($sformatf("hold%0d", i), 0);
    end
    en = 1'b1;
    next_pix();
    check_idle("start", 0);
    for (int k = 0; k < 336; k++) begin
      next_pix();
      check_pix(k);
    end
    for (int p = 0; p < 112; p++) begin
      next_pix();
      check_pix(336 + p);
      if (p == 17) en = 1'b0;
    end
    for (int i = 0; i < 20; i++) begin
      next_pix();
      check_idle($sformatf("held%0d", i), 4);
    end
    en = 1'b1;
    next_pix();
    check_idle("restart", 4);
    next_pix();
    check("restart_fstart", 32'(frame_start), 1);
    check("restart_bright", 32'(bright), 1);
    check("restart_x", 32'(x), 0);
    check("restart_fcnt", 32'(frame_cnt), 4);
    next_pix();
    next_pix();
    check("pre_rst_x", 32'(x), 2);
    @(posedge clk);
    #2;
    check("pre_rst_pce", 32'(pix_ce), 1);
    rst_n = 1'b0;
    #1;
    check("arst_pce", 32'(pix_ce), 0);
    check("arst_x", 32'(x), 0);
    check("arst_y", 32'(y), 0);
    check("arst_lstart", 32'(line_start), 0);
    check_idle("arst", 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("arst_hold_pce%0d", i), 32'(pix_ce), 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
